data_mem_responder: RTL and testbench

Multi-cycle data-memory responder for the pipelined CPU's MEM stage: the target end of the data-memory request interface. It accepts one read or write request at a time over a valid/ready handshake and holds it for a fixed, configurable latency. It then returns a response (read data or write acknowledge, plus an error flag) over a second valid/ready handshake. It lets the CPU move from a zero-latency memory model to a stall-driven memory protocol.

---
 rtl/data_mem_responder.sv | 52 +++++
 tb/tb_data_mem_responder.sv | 158 +++++++++++++++
 2 files changed

// File: rtl/data_mem_responder.sv
// data_mem_responder: multi-cycle data-memory target that accepts one request over valid/ready,
// holds it for a fixed LATENCY and returns read data or a write acknowledge plus an error flag.
module data_mem_responder #(
  parameter int ADDR_WIDTH = 14,
  parameter int LATENCY    = 3
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic        busy
);
  localparam logic [1:0] IDLE = 2'd0, WAIT = 2'd1, RESP = 2'd2;
  localparam logic [3:0] CNT_INIT = 4'(LATENCY > 1 ? LATENCY - 2 : 0);
  logic [1:0] state;
  logic [3:0] count;
  logic [31:0] mem [2**ADDR_WIDTH] = '{default: '0};
  logic [ADDR_WIDTH-1:0] idx;
  logic err, accept;
  assign idx        = req_addr[ADDR_WIDTH+1:2];
  assign err        = (|req_addr[1:0]) || (|(req_addr >> (ADDR_WIDTH + 2)));
  assign accept     = reset && state == IDLE && req_valid;
  assign req_ready  = state == IDLE;
  assign resp_valid = state == RESP;
  assign busy       = state != IDLE;
  // Storage is deliberately outside the reset domain so committed stores survive a reset.
  always_ff @(posedge clk)
    if (accept && req_write && !err) mem[idx] <= req_wdata;
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      state      <= IDLE;
      count      <= '0;
      resp_rdata <= '0;
      resp_err   <= 1'b0;
    end else begin
      if (accept) begin
        resp_rdata <= (req_write || err) ? '0 : mem[idx];
        resp_err   <= err;
      end
      state <= accept ? (LATENCY == 1 ? RESP : WAIT) :
               (state == WAIT && count == '0) ? RESP :
               (state == RESP && resp_ready) ? IDLE : state;
      count <= accept ? CNT_INIT : (state == WAIT && count != '0) ? count - 4'd1 : count;
    end
endmodule

// File: tb/tb_data_mem_responder.sv
// tb_data_mem_responder: table-driven checks of a LATENCY=3 responder plus a LATENCY=1 back-to-back run.
module tb_data_mem_responder;
  logic clk = 1'b0, reset = 1'b0;
  always #5 clk = ~clk;
  logic req_valid = 1'b0, req_write = 1'b0, resp_ready = 1'b0;
  logic [31:0] req_addr = '0, req_wdata = '0;
  logic req_ready, resp_valid, resp_err, busy;
  logic [31:0] resp_rdata;
  logic b_req_valid = 1'b0, b_req_write = 1'b0, b_resp_ready = 1'b0;
  logic [31:0] b_req_addr = '0, b_req_wdata = '0;
  logic b_req_ready, b_resp_valid, b_resp_err, b_busy;
  logic [31:0] b_resp_rdata;

  data_mem_responder #(.ADDR_WIDTH(14), .LATENCY(3)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_rdata(resp_rdata),
    .resp_err(resp_err), .busy(busy));

  data_mem_responder #(.ADDR_WIDTH(14), .LATENCY(1)) dut_b (
    .clk(clk), .reset(reset), .req_valid(b_req_valid), .req_ready(b_req_ready),
    .req_write(b_req_write), .req_addr(b_req_addr), .req_wdata(b_req_wdata),
    .resp_valid(b_resp_valid), .resp_ready(b_resp_ready), .resp_rdata(b_resp_rdata),
    .resp_err(b_resp_err), .busy(b_busy));

  typedef struct { logic [31:0] rdata; logic err; } resp_t;
  typedef struct {
    logic w; logic [31:0] addr; logic [31:0] wdata; int hold; logic junk;
    logic [31:0] rdata; logic err;
  } vec_t;
  resp_t sb[$];
  resp_t sb_b[$];
  vec_t vecs[14];
  logic [31:0] junk_addrs[4] = '{32'h40, 32'h44, 32'hFFFC, 32'h42};
  logic [31:0] bref[int];
  int n_tests = 0, n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic do_req(input vec_t v);
    int lat = 0;
    resp_t e;
    logic [31:0] held;
    @(negedge clk);
    reset = 1'b1; req_valid = 1'b1; req_write = v.w; req_addr = v.addr; req_wdata = v.wdata;
    resp_ready = 1'b0;
    check("req_ready_idle", {31'b0, req_ready}, 32'd1);
    sb.push_back('{v.rdata, v.err});
    do begin
      @(negedge clk);
      lat++;
      if (lat == 1) check("wait_busy", {30'b0, busy, req_ready}, 32'd2);
      if (v.junk && !resp_valid) begin
        req_write = 1'($urandom_range(0, 1));
        req_addr  = junk_addrs[$urandom_range(0, 3)];
        req_wdata = $urandom;
      end else req_valid = 1'b0;
    end while (!resp_valid && lat < 20);
    req_valid = 1'b0;
    check("latency", lat, 32'd3);
    e = sb.size() > 0 ? sb.pop_front() : '{32'hX, 1'bx};
    check("resp_valid", {31'b0, resp_valid}, 32'd1);
    check("resp_rdata", resp_rdata, e.rdata);
    check("resp_err", {31'b0, resp_err}, {31'b0, e.err});
    held = resp_rdata;
    for (int i = 0; i < v.hold; i++) begin
      @(negedge clk);
      check("bp_valid", {31'b0, resp_valid}, 32'd1);
      check("bp_rdata", resp_rdata, held);
      check("bp_req_ready", {31'b0, req_ready}, 32'd0);
    end
    resp_ready = 1'b1;
    check("hs_req_ready", {31'b0, req_ready}, 32'd0);
    @(negedge clk);
    resp_ready = 1'b0;
    check("post_req_ready", {31'b0, req_ready}, 32'd1);
    check("post_resp_valid", {31'b0, resp_valid}, 32'd0);
    check("post_busy", {31'b0, busy}, 32'd0);
  endtask

  initial begin
    logic [31:0] b_addr[12], b_d[12];
    logic b_w[12];
    int k, nresp, last, cyc, idx;
    resp_t e;
    vecs[0]  = '{1'b1, 32'h40,       32'hDEADBEEF, 0, 1'b0, 32'h0,        1'b0};
    vecs[1]  = '{1'b0, 32'h40,       32'h0,        5, 1'b0, 32'hDEADBEEF, 1'b0};
    vecs[2]  = '{1'b1, 32'h42,       32'h11111111, 0, 1'b0, 32'h0,        1'b1};
    vecs[3]  = '{1'b0, 32'h40,       32'h0,        0, 1'b0, 32'hDEADBEEF, 1'b0};
    vecs[4]  = '{1'b0, 32'h10000,    32'h0,        0, 1'b0, 32'h0,        1'b1};
    vecs[5]  = '{1'b0, 32'h44,       32'h0,        0, 1'b0, 32'h0,        1'b0};
    vecs[6]  = '{1'b1, 32'hFFFC,     32'hCAFEF00D, 0, 1'b0, 32'h0,        1'b0};
    vecs[7]  = '{1'b0, 32'hFFFC,     32'h0,        0, 1'b0, 32'hCAFEF00D, 1'b0};
    vecs[8]  = '{1'b0, 32'h80000040, 32'h0,        0, 1'b0, 32'h0,        1'b1};
    vecs[9]  = '{1'b1, 32'h100,      32'h12345678, 0, 1'b1, 32'h0,        1'b0};
    vecs[10] = '{1'b0, 32'h100,      32'h0,        0, 1'b1, 32'h12345678, 1'b0};
    vecs[11] = '{1'b0, 32'h40,       32'h0,        0, 1'b0, 32'hDEADBEEF, 1'b0};
    vecs[12] = '{1'b0, 32'h44,       32'h0,        0, 1'b0, 32'h0,        1'b0};
    vecs[13] = '{1'b0, 32'hFFFC,     32'h0,        0, 1'b0, 32'hCAFEF00D, 1'b0};
    #1;
    check("rst_req_ready", {31'b0, req_ready}, 32'd1);
    check("rst_resp_valid", {31'b0, resp_valid}, 32'd0);
    check("rst_rdata", resp_rdata, 32'd0);
    check("rst_err", {31'b0, resp_err}, 32'd0);
    check("rst_busy", {31'b0, busy}, 32'd0);
    @(negedge clk);
    reset = 1'b1;
    for (int i = 0; i < 14; i++) do_req(vecs[i]);
    // Reset while a store sits in WAIT: outputs drop without a clock edge, the store stays committed.
    @(negedge clk);
    req_valid = 1'b1; req_write = 1'b1; req_addr = 32'h200; req_wdata = 32'hA5A5A5A5;
    @(negedge clk);
    req_valid = 1'b0;
    check("midwait_busy", {31'b0, busy}, 32'd1);
    #1 reset = 1'b0;
    #1;
    check("async_req_ready", {31'b0, req_ready}, 32'd1);
    check("async_resp_valid", {31'b0, resp_valid}, 32'd0);
    check("async_busy", {31'b0, busy}, 32'd0);
    do_req('{1'b0, 32'h200, 32'h0, 0, 1'b0, 32'hA5A5A5A5, 1'b0});
    for (int i = 0; i < 12; i++) begin
      b_w[i] = i < 4;
      b_d[i] = $urandom;
      idx = i < 4 || i >= 10 ? int'($urandom_range(0, 16383)) : int'(b_addr[i-4] >> 2);
      b_addr[i] = 32'(idx) << 2;
    end
    k = 0; nresp = 0; last = 0; cyc = 0;
    b_resp_ready = 1'b1;
    while (nresp < 12 && cyc < 200) begin
      @(negedge clk);
      cyc++;
      if (b_resp_valid) begin
        e = sb_b.size() > 0 ? sb_b.pop_front() : '{32'hX, 1'bx};
        check("b_rdata", b_resp_rdata, e.rdata);
        check("b_err", {31'b0, b_resp_err}, 32'd0);
        if (nresp > 0) check("b_interval", cyc - last, 32'd2);
        last = cyc;
        nresp++;
      end
      if (b_req_ready && k < 12) begin
        b_req_valid = 1'b1; b_req_write = b_w[k]; b_req_addr = b_addr[k]; b_req_wdata = b_d[k];
        idx = int'(b_addr[k] >> 2);
        sb_b.push_back('{b_w[k] ? 32'h0 : (bref.exists(idx) ? bref[idx] : 32'h0), 1'b0});
        if (b_w[k]) bref[idx] = b_d[k];
        k++;
      end else if (k == 12) b_req_valid = 1'b0;
    end
    check("b_resp_count", nresp, 32'd12);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
